pipelined_result_rounder: RTL and testbench

Parametrised, pipelined successor to the combinational rounder in the FP datapath. It takes a non-rounded sign/exponent/mantissa plus extra rounding bits and applies one of five IEEE-754 rounding modes, selected per transaction. It produces the rounded result with overflow and inexact flags. It sits between the normalise stage of the add/mul units and the result packer, and uses a valid/ready handshake with full backpressure.

---
 rtl/pipelined_result_rounder.sv | 173 +++++++++++++++++
 tb/tb_pipelined_result_rounder.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_result_rounder.sv
// ============================================================================
// Module   : pipelined_result_rounder
// Purpose  : Two-stage pipelined IEEE-754 rounder. Takes an unrounded
//            sign/exponent/mantissa plus guard/sticky bits and applies one of
//            five rounding modes per transaction, producing the rounded value
//            with overflow and inexact flags. Valid/ready handshake with full
//            backpressure; throughput one result per cycle.
// Ports    :
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid / in_ready    input handshake (in_ready depends only on output side)
//   in_sign                sign, passed through unchanged
//   in_exponent            unrounded biased exponent
//   in_mantissa            unrounded stored mantissa (hidden bit excluded)
//   in_rounding_bits       bits below mantissa LSB: MSB guard, rest sticky
//   in_rounding_mode       0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5..7 default
//   out_valid / out_ready  output handshake
//   out_sign/exponent/mantissa  rounded result
//   out_overflow           rounding carried exponent to all-ones (result Inf)
//   out_inexact            rounding bits were non-zero
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_result_rounder #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int ROUNDING_BITS  = 3,
  parameter int DEFAULT_MODE   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXPONENT_WIDTH-1:0] in_exponent,
  input  logic [MANTISSA_WIDTH-1:0] in_mantissa,
  input  logic [ROUNDING_BITS-1:0]  in_rounding_bits,
  input  logic [2:0]                in_rounding_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sign,
  output logic [EXPONENT_WIDTH-1:0] out_exponent,
  output logic [MANTISSA_WIDTH-1:0] out_mantissa,
  output logic                      out_overflow,
  output logic                      out_inexact
);

  localparam logic [2:0] C_MODE_RNE = 3'd0;
  localparam logic [2:0] C_MODE_RTZ = 3'd1;
  localparam logic [2:0] C_MODE_RDN = 3'd2;
  localparam logic [2:0] C_MODE_RUP = 3'd3;
  localparam logic [2:0] C_MODE_RMM = 3'd4;
  localparam logic [2:0] C_MODE_DEF = 3'(DEFAULT_MODE);

  // --------------------------------------------------------------------------
  // Handshake: whole pipeline moves together whenever the output register is
  // empty or being drained.
  // --------------------------------------------------------------------------
  logic w_advance;
  logic r_s2_valid;

  assign w_advance = !r_s2_valid || out_ready;
  assign in_ready  = w_advance;

  // --------------------------------------------------------------------------
  // Stage 1: rounding decision
  // --------------------------------------------------------------------------
  logic       w_guard;
  logic       w_sticky;
  logic       w_any;
  logic       w_special;
  logic [2:0] w_mode;
  logic       w_round_up;
  logic       w_inexact;

  assign w_guard   = in_rounding_bits[ROUNDING_BITS-1];
  assign w_sticky  = |in_rounding_bits[ROUNDING_BITS-2:0];
  assign w_any     = w_guard | w_sticky;
  assign w_special = &in_exponent;   // Inf/NaN: never rounded
  assign w_mode    = (in_rounding_mode > C_MODE_RMM) ? C_MODE_DEF : in_rounding_mode;

  always_comb begin
    w_round_up = 1'b0;
    case (w_mode)
      C_MODE_RNE: w_round_up = w_guard && (w_sticky || in_mantissa[0]);
      C_MODE_RTZ: w_round_up = 1'b0;
      C_MODE_RDN: w_round_up = in_sign && w_any;
      C_MODE_RUP: w_round_up = !in_sign && w_any;
      C_MODE_RMM: w_round_up = w_guard;
      default:    w_round_up = 1'b0;
    endcase
    if (w_special) begin
      w_round_up = 1'b0;
    end
  end

  assign w_inexact = w_any && !w_special;

  logic                      r_s1_valid;
  logic                      r_s1_sign;
  logic [EXPONENT_WIDTH-1:0] r_s1_exponent;
  logic [MANTISSA_WIDTH-1:0] r_s1_mantissa;
  logic                      r_s1_round_up;
  logic                      r_s1_inexact;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_sign     <= 1'b0;
      r_s1_exponent <= '0;
      r_s1_mantissa <= '0;
      r_s1_round_up <= 1'b0;
      r_s1_inexact  <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid    <= in_valid;
      r_s1_sign     <= in_sign;
      r_s1_exponent <= in_exponent;
      r_s1_mantissa <= in_mantissa;
      r_s1_round_up <= w_round_up;
      r_s1_inexact  <= w_inexact;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: increment with carry into the exponent
  // --------------------------------------------------------------------------
  logic [MANTISSA_WIDTH:0]   w_mant_sum;
  logic                      w_carry;
  logic [EXPONENT_WIDTH-1:0] w_exp_next;
  logic                      w_overflow;
  logic [MANTISSA_WIDTH-1:0] w_mant_next;

  assign w_mant_sum  = {1'b0, r_s1_mantissa} + {{MANTISSA_WIDTH{1'b0}}, r_s1_round_up};
  assign w_carry     = w_mant_sum[MANTISSA_WIDTH];
  assign w_exp_next  = r_s1_exponent + {{(EXPONENT_WIDTH-1){1'b0}}, w_carry};
  // Only a rounding carry can reach all-ones: special inputs never round up.
  assign w_overflow  = w_carry && (&w_exp_next);
  assign w_mant_next = w_overflow ? '0 : w_mant_sum[MANTISSA_WIDTH-1:0];

  logic                      r_s2_sign;
  logic [EXPONENT_WIDTH-1:0] r_s2_exponent;
  logic [MANTISSA_WIDTH-1:0] r_s2_mantissa;
  logic                      r_s2_overflow;
  logic                      r_s2_inexact;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid    <= 1'b0;
      r_s2_sign     <= 1'b0;
      r_s2_exponent <= '0;
      r_s2_mantissa <= '0;
      r_s2_overflow <= 1'b0;
      r_s2_inexact  <= 1'b0;
    end else if (w_advance) begin
      r_s2_valid    <= r_s1_valid;
      r_s2_sign     <= r_s1_sign;
      r_s2_exponent <= w_exp_next;
      r_s2_mantissa <= w_mant_next;
      r_s2_overflow <= w_overflow;
      r_s2_inexact  <= r_s1_inexact | w_overflow;
    end
  end

  assign out_valid    = r_s2_valid;
  assign out_sign     = r_s2_sign;
  assign out_exponent = r_s2_exponent;
  assign out_mantissa = r_s2_mantissa;
  assign out_overflow = r_s2_overflow;
  assign out_inexact  = r_s2_inexact;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_result_rounder.sv
// ============================================================================
// Module   : tb_pipelined_result_rounder
// Purpose  : Self-checking bench for pipelined_result_rounder: directed
//            rounding cases, stall/backpressure, reset while busy, and a
//            randomized stream checked against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_result_rounder;

  localparam int EW  = 8;
  localparam int MW  = 23;
  localparam int RB  = 3;
  localparam int DEF = 0;

  typedef struct packed {
    logic          s;
    logic [EW-1:0] e;
    logic [MW-1:0] m;
    logic          ovf;
    logic          inex;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [EW-1:0] in_exponent;
  logic [MW-1:0] in_mantissa;
  logic [RB-1:0] in_rounding_bits;
  logic [2:0]    in_rounding_mode;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [EW-1:0] out_exponent;
  logic [MW-1:0] out_mantissa;
  logic          out_overflow;
  logic          out_inexact;

  int   vectors = 0;
  int   errors  = 0;
  int   lat;
  res_t got;
  res_t exp_q[$];

  always #5 clk = ~clk;

  pipelined_result_rounder #(
    .EXPONENT_WIDTH(EW), .MANTISSA_WIDTH(MW), .ROUNDING_BITS(RB), .DEFAULT_MODE(DEF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exponent(in_exponent), .in_mantissa(in_mantissa),
    .in_rounding_bits(in_rounding_bits), .in_rounding_mode(in_rounding_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exponent(out_exponent), .out_mantissa(out_mantissa),
    .out_overflow(out_overflow), .out_inexact(out_inexact)
  );

  // Reference: treat {exp,mant} as one magnitude, decide round-up from the
  // remainder compared with one half ulp, then add.
  function automatic res_t model(input logic s, input logic [EW-1:0] e,
                                 input logic [MW-1:0] m, input logic [RB-1:0] rb,
                                 input logic [2:0] mode);
    res_t             r;
    int               md;
    int               rem;
    int               half;
    bit               up;
    logic [EW+MW-1:0] mag;
    r.s  = s;
    md   = (mode > 3'd4) ? DEF : int'(mode);
    rem  = int'(rb);
    half = 1 << (RB - 1);
    if (e == '1) begin
      r.e = e; r.m = m; r.ovf = 1'b0; r.inex = 1'b0;
      return r;
    end
    case (md)
      0:       up = (rem > half) || (rem == half && m[0]);
      1:       up = 1'b0;
      2:       up = s && (rem != 0);
      3:       up = !s && (rem != 0);
      default: up = (rem >= half);
    endcase
    mag   = {e, m} + (EW+MW)'(up);
    r.e   = mag[EW+MW-1:MW];
    r.m   = mag[MW-1:0];
    r.ovf = 1'b0;
    if (r.e == '1) begin
      r.m   = '0;
      r.ovf = 1'b1;
    end
    r.inex = (rem != 0);
    return r;
  endfunction

  // Present one transaction and hold it until the handshake completes; the
  // model result is queued at the accepting edge.
  task automatic drive_txn(input logic s, input logic [EW-1:0] e, input logic [MW-1:0] m,
                           input logic [RB-1:0] rb, input logic [2:0] mode);
    bit acc = 1'b0;
    int n   = 0;
    @(negedge clk);
    in_valid = 1'b1; in_sign = s; in_exponent = e; in_mantissa = m;
    in_rounding_bits = rb; in_rounding_mode = mode;
    while (!acc && n < 200) begin
      #4;
      acc = in_ready;
      @(posedge clk);
      n++;
      if (!acc) @(negedge clk);
    end
    if (acc) exp_q.push_back(model(s, e, m, rb, mode));
    else begin
      vectors++; errors++;
      $display("FAIL handshake_timeout: in_ready stayed %b, required 1 within 200 cycles", in_ready);
    end
    #1 in_valid = 1'b0;
  endtask

  // Single transaction with out_ready high; captures result and latency in
  // edges counted from (and including) the accepting edge.
  task automatic apply_one(input logic s, input logic [EW-1:0] e, input logic [MW-1:0] m,
                           input logic [RB-1:0] rb, input logic [2:0] mode);
    out_ready = 1'b1;
    exp_q.delete();
    drive_txn(s, e, m, rb, mode);
    lat = 1;
    forever begin
      @(negedge clk); #1;
      if (out_valid || lat >= 10) break;
      @(posedge clk);
      lat++;
    end
    got = '{out_sign, out_exponent, out_mantissa, out_overflow, out_inexact};
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 1'b0; in_exponent = '0; in_mantissa = '0;
    in_rounding_bits = '0; in_rounding_mode = '0;
    #2;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_valid: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    vectors++;
    if ({out_sign, out_exponent, out_mantissa, out_overflow, out_inexact} !== '0) begin
      errors++;
      $display("FAIL reset_data: e=%h m=%h ovf=%b inx=%b, required all zero",
               out_exponent, out_mantissa, out_overflow, out_inexact);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rne();
    apply_one(1'b0, 8'h7F, 23'h7FFFFF, 3'b100, 3'd0);
    vectors++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL latency: %0d edges, required 2", lat);
    end
    vectors++;
    if (got.e !== 8'h80 || got.m !== 23'h0 || got.ovf !== 1'b0 || got.inex !== 1'b1) begin
      errors++;
      $display("FAIL rne_odd_tie: e=%h m=%h ovf=%b inx=%b, required 80/000000/0/1", got.e, got.m, got.ovf, got.inex);
    end
    apply_one(1'b0, 8'h7F, 23'h000002, 3'b100, 3'd0);
    vectors++;
    if (got.e !== 8'h7F || got.m !== 23'h000002 || got.inex !== 1'b1 || lat !== 2) begin
      errors++;
      $display("FAIL rne_even_tie: e=%h m=%h inx=%b lat=%0d, required 7f/000002/1/2", got.e, got.m, got.inex, lat);
    end
    apply_one(1'b0, 8'h7F, 23'h000002, 3'b101, 3'd0);
    vectors++;
    if (got.m !== 23'h000003 || got.inex !== 1'b1) begin
      errors++;
      $display("FAIL rne_above_half: m=%h inx=%b, required 000003/1", got.m, got.inex);
    end
  endtask

  task automatic test_overflow();
    apply_one(1'b0, 8'hFE, 23'h7FFFFF, 3'b110, 3'd0);
    vectors++;
    if (got.e !== 8'hFF || got.m !== 23'h0 || got.ovf !== 1'b1 || got.inex !== 1'b1) begin
      errors++;
      $display("FAIL overflow_rne: e=%h m=%h ovf=%b inx=%b, required ff/000000/1/1", got.e, got.m, got.ovf, got.inex);
    end
    apply_one(1'b0, 8'hFE, 23'h7FFFFF, 3'b110, 3'd1);
    vectors++;
    if (got.e !== 8'hFE || got.m !== 23'h7FFFFF || got.ovf !== 1'b0 || got.inex !== 1'b1) begin
      errors++;
      $display("FAIL overflow_rtz: e=%h m=%h ovf=%b inx=%b, required fe/7fffff/0/1", got.e, got.m, got.ovf, got.inex);
    end
  endtask

  task automatic test_modes();
    logic [MW-1:0] want [5];
    logic          sg   [5];
    logic [2:0]    md   [5];
    want = '{23'h000011, 23'h000010, 23'h000011, 23'h000010, 23'h000004};
    sg   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    md   = '{3'd2, 3'd2, 3'd3, 3'd4, 3'd7};
    for (int i = 0; i < 5; i++) begin
      // Last entry: odd-LSB tie under undefined code 7 must round as RNE.
      if (i == 4) apply_one(sg[i], 8'h7F, 23'h000003, 3'b100, md[i]);
      else        apply_one(sg[i], 8'h7F, 23'h000010, 3'b001, md[i]);
      vectors++;
      if (got.m !== want[i] || got.s !== sg[i] || got.inex !== 1'b1) begin
        errors++;
        $display("FAIL mode_%0d_sign_%0b: m=%h s=%b inx=%b, required %h/%b/1",
                 md[i], sg[i], got.m, got.s, got.inex, want[i], sg[i]);
      end
    end
  endtask

  task automatic test_special();
    apply_one(1'b1, 8'hFF, 23'h400000, 3'b111, 3'd3);
    vectors++;
    if (got.s !== 1'b1 || got.e !== 8'hFF || got.m !== 23'h400000 || got.ovf !== 1'b0 || got.inex !== 1'b0) begin
      errors++;
      $display("FAIL special_passthru: s=%b e=%h m=%h ovf=%b inx=%b, required 1/ff/400000/0/0",
               got.s, got.e, got.m, got.ovf, got.inex);
    end
  endtask

  task automatic test_back_to_back();
    res_t snap;
    res_t ex;
    bit   seen = 1'b0;
    int   n    = 0;
    int   cyc  = 0;
    out_ready = 1'b1;
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < 4; i++)
          drive_txn(1'($urandom), 8'h40 + 8'(i), 23'($urandom), 3'($urandom), 3'(i));
      end
      begin
        while (!seen && cyc < 50) begin
          @(negedge clk); #1; cyc++;
          if (out_valid) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
          errors++;
          $display("FAIL bp_first_valid: out_valid=%b, required 1 within 50 cycles", out_valid);
        end else begin
          out_ready = 1'b0;
          snap = '{out_sign, out_exponent, out_mantissa, out_overflow, out_inexact};
          for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                {out_sign, out_exponent, out_mantissa, out_overflow, out_inexact} !== snap) begin
              errors++;
              $display("FAIL bp_stall_%0d: in_ready=%b out_valid=%b e=%h m=%h, required 0/1/%h/%h",
                       k, in_ready, out_valid, out_exponent, out_mantissa, snap.e, snap.m);
            end
          end
          out_ready = 1'b1;
          cyc = 0;
          while (n < 4 && cyc < 50) begin
            if (out_valid) begin
              vectors++;
              if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bp_extra_output: e=%h m=%h, required no output", out_exponent, out_mantissa);
              end else begin
                ex = exp_q.pop_front();
                if ({out_sign, out_exponent, out_mantissa, out_overflow, out_inexact} !== ex) begin
                  errors++;
                  $display("FAIL bp_result_%0d: s=%b e=%h m=%h ovf=%b inx=%b, required %b/%h/%h/%b/%b",
                           n, out_sign, out_exponent, out_mantissa, out_overflow, out_inexact,
                           ex.s, ex.e, ex.m, ex.ovf, ex.inex);
                end
              end
              n++;
            end
            @(negedge clk); #1; cyc++;
          end
        end
      end
    join
    vectors++;
    if (n !== 4) begin
      errors++;
      $display("FAIL bp_count: %0d results delivered, required 4", n);
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_duplicate: out_valid=%b after all results, required 0", out_valid);
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b1;
    exp_q.delete();
    drive_txn(1'b0, 8'h10, 23'h000123, 3'b110, 3'd0);
    drive_txn(1'b1, 8'h11, 23'h000456, 3'b010, 3'd2);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_exponent !== '0) begin
      errors++;
      $display("FAIL reset_inflight: out_valid=%b e=%h, required 0/00", out_valid, out_exponent);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      vectors++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_stale_%0d: out_valid=%b, required 0", k, out_valid);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_random_stream(input int count);
    res_t ex;
    int   n   = 0;
    int   cyc = 0;
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < count; i++) begin
          logic [EW-1:0] e;
          logic [MW-1:0] m;
          case ($urandom_range(0, 3))
            0:       e = 8'hFE;
            1:       e = 8'hFF;
            default: e = 8'($urandom);
          endcase
          case ($urandom_range(0, 2))
            0:       m = '1;
            default: m = 23'($urandom);
          endcase
          if ($urandom_range(0, 3) == 0) @(negedge clk);
          drive_txn(1'($urandom), e, m, 3'($urandom), 3'($urandom_range(0, 7)));
        end
      end
      begin
        while (n < count && cyc < count * 20) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
          #1; cyc++;
          if (out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL rand_unexpected: e=%h m=%h, required no output", out_exponent, out_mantissa);
            end else begin
              ex = exp_q.pop_front();
              if ({out_sign, out_exponent, out_mantissa, out_overflow, out_inexact} !== ex) begin
                errors++;
                $display("FAIL rand_%0d: s=%b e=%h m=%h ovf=%b inx=%b, required %b/%h/%h/%b/%b",
                         n, out_sign, out_exponent, out_mantissa, out_overflow, out_inexact,
                         ex.s, ex.e, ex.m, ex.ovf, ex.inex);
              end
            end
            n++;
          end
        end
        out_ready = 1'b1;
      end
    join
    vectors++;
    if (n !== count) begin
      errors++;
      $display("FAIL rand_count: %0d results, required %0d", n, count);
    end
  endtask

  initial begin
    test_reset();
    test_rne();
    test_overflow();
    test_modes();
    test_special();
    test_back_to_back();
    test_reset_inflight();
    test_random_stream(300);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
